// File: rtl/placement_eval.sv
// Purpose: scores a finished placement (edge wirelength cost, longest edge) and checks node legality/overlap.
// Latency: 7 cycles per edge + 3 cycles per node + 2; done rises 7*N_EDGE+3*N_NODE+2 cycles after start.
// Backpressure: none; memories are fixed-latency, start is ignored while busy.
module placement_eval #(
  parameter int N_GRID = 9,
  parameter int N_EDGE = 91,
  parameter int N_NODE = 64,
  parameter int W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [W-1:0]        err_node,
  output logic signed [W-1:0] cost,
  output logic [W-1:0]        max_len,
  output logic                edge_re,
  output logic [W-1:0]        edge_addr,
  input  logic [W-1:0]        ea_data,
  input  logic [W-1:0]        eb_data,
  output logic                pos_re,
  output logic [W-1:0]        pos_addr,
  input  logic signed [W-1:0] posx_data,
  input  logic signed [W-1:0] posy_data
);

  localparam int NB = N_GRID * N_GRID;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (N_GRID > 1) ? $clog2(N_GRID) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_E_RD, S_E_WAIT, S_PA_RD, S_PA_WAIT, S_PB_RD, S_PB_WAIT,
    S_E_ACC, S_N_RD, S_N_WAIT, S_N_CHK, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        i_q, i_d, k_q, k_d;
  logic [W-1:0]        a_id_q, a_id_d, b_id_q, b_id_d;
  logic [W-1:0]        ax_q, ax_d, ay_q, ay_d;
  logic [1:0]          err_q, err_d;
  logic [W-1:0]        err_node_q, err_node_d;
  logic signed [W-1:0] cost_q, cost_d;
  logic [W-1:0]        max_len_q, max_len_d;
  logic                edge_re_q, edge_re_d, pos_re_q, pos_re_d;
  logic [W-1:0]        edge_addr_q, edge_addr_d, pos_addr_q, pos_addr_d;
  logic [NB-1:0]       bitmap_q, bitmap_d;

  logic [W-1:0]        d_len;
  logic [IW-1:0]       cell_idx;
  logic                a_ok, b_ok;

  // A coordinate is legal when non-negative and strictly below the grid side.
  function automatic logic in_range(input logic [W-1:0] v);
    return !v[W-1] && (v < W'(N_GRID));
  endfunction

  // |a-b| in W-bit two's complement.
  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    t = a - b;
    return t[W-1] ? -t : t;
  endfunction

  // Edge length uses the latched A endpoint and the B endpoint arriving now.
  assign d_len    = abs_diff(ax_q, posx_data) + abs_diff(ay_q, posy_data);
  assign a_ok     = in_range(ax_q) && in_range(ay_q);
  assign b_ok     = in_range(posx_data) && in_range(posy_data);
  assign cell_idx = IW'(posx_data[CW-1:0]) * IW'(N_GRID) + IW'(posy_data[CW-1:0]);

  // Next-state and datapath control: edge pass, then node pass, then DONE.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    k_d         = k_q;
    a_id_d      = a_id_q;
    b_id_d      = b_id_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    err_d       = err_q;
    err_node_d  = err_node_q;
    cost_d      = cost_q;
    max_len_d   = max_len_q;
    edge_re_d   = 1'b0;
    pos_re_d    = 1'b0;
    edge_addr_d = edge_addr_q;
    pos_addr_d  = pos_addr_q;
    bitmap_d    = bitmap_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cost_d     = '0;
          max_len_d  = '0;
          err_d      = 2'd0;
          err_node_d = '0;
          i_d        = '0;
          k_d        = '0;
          bitmap_d   = '0;
          state_d    = S_E_RD;
        end
      end
      S_E_RD: begin
        if (i_q == W'(N_EDGE)) begin
          state_d = S_N_RD;
        end else begin
          edge_re_d   = 1'b1;
          edge_addr_d = i_q;
          state_d     = S_E_WAIT;
        end
      end
      S_E_WAIT:  state_d = S_PA_RD;
      S_PA_RD: begin
        a_id_d     = ea_data;
        b_id_d     = eb_data;
        pos_re_d   = 1'b1;
        pos_addr_d = ea_data;
        state_d    = S_PA_WAIT;
      end
      S_PA_WAIT: state_d = S_PB_RD;
      S_PB_RD: begin
        ax_d       = posx_data;
        ay_d       = posy_data;
        pos_re_d   = 1'b1;
        pos_addr_d = b_id_q;
        state_d    = S_PB_WAIT;
      end
      S_PB_WAIT: state_d = S_E_ACC;
      S_E_ACC: begin
        if (!a_ok) begin
          err_d      = 2'd1;
          err_node_d = a_id_q;
          state_d    = S_DONE;
        end else if (!b_ok) begin
          err_d      = 2'd1;
          err_node_d = b_id_q;
          state_d    = S_DONE;
        end else begin
          cost_d    = cost_q + $signed(d_len) - 1;
          max_len_d = (d_len > max_len_q) ? d_len : max_len_q;
          i_d       = i_q + 1'b1;
          state_d   = S_E_RD;
        end
      end
      S_N_RD: begin
        if (k_q == W'(N_NODE)) begin
          state_d = S_DONE;
        end else begin
          pos_re_d   = 1'b1;
          pos_addr_d = k_q;
          state_d    = S_N_WAIT;
        end
      end
      S_N_WAIT:  state_d = S_N_CHK;
      S_N_CHK: begin
        if (!b_ok) begin
          err_d      = 2'd1;
          err_node_d = k_q;
          state_d    = S_DONE;
        end else if (bitmap_q[cell_idx]) begin
          err_d      = 2'd2;
          err_node_d = k_q;
          state_d    = S_DONE;
        end else begin
          bitmap_d[cell_idx] = 1'b1;
          k_d                = k_q + 1'b1;
          state_d            = S_N_RD;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State and result registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      k_q         <= '0;
      a_id_q      <= '0;
      b_id_q      <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      err_q       <= 2'd0;
      err_node_q  <= '0;
      cost_q      <= '0;
      max_len_q   <= '0;
      edge_re_q   <= 1'b0;
      pos_re_q    <= 1'b0;
      edge_addr_q <= '0;
      pos_addr_q  <= '0;
      bitmap_q    <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      k_q         <= k_d;
      a_id_q      <= a_id_d;
      b_id_q      <= b_id_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      err_q       <= err_d;
      err_node_q  <= err_node_d;
      cost_q      <= cost_d;
      max_len_q   <= max_len_d;
      edge_re_q   <= edge_re_d;
      pos_re_q    <= pos_re_d;
      edge_addr_q <= edge_addr_d;
      pos_addr_q  <= pos_addr_d;
      bitmap_q    <= bitmap_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign err_node  = err_node_q;
  assign cost      = cost_q;
  assign max_len   = max_len_q;
  assign edge_re   = edge_re_q;
  assign edge_addr = edge_addr_q;
  assign pos_re    = pos_re_q;
  assign pos_addr  = pos_addr_q;

endmodule

// File: tb/tb_placement_eval.sv
// Purpose: directed checks of placement_eval on three parameterisations sharing one memory image.
// Latency: checks exact start-to-done cycle counts against the closed-form figures.
// Backpressure: n/a; memories answer one cycle after sampling their read enable.
module tb_placement_eval;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] ea_mem [128];
  logic [W-1:0] eb_mem [128];
  logic [W-1:0] px_mem [128];
  logic [W-1:0] py_mem [128];

  int n_checks = 0;
  int n_errors = 0;
  int ovl_s = 0;
  int ovl_f = 0;

  // s_: 2 edges / 3 nodes, z_: 0 edges / 3 nodes, f_: default 91 / 64
  logic s_start = 1'b0, z_start = 1'b0, f_start = 1'b0;
  logic s_busy, s_done, z_busy, z_done, f_busy, f_done;
  logic [1:0] s_err, z_err, f_err;
  logic [W-1:0] s_en, s_ml, z_en, z_ml, f_en, f_ml;
  logic signed [W-1:0] s_cost, z_cost, f_cost;
  logic s_ere, s_pre, z_ere, z_pre, f_ere, f_pre;
  logic [W-1:0] s_eaddr, s_paddr, z_eaddr, z_paddr, f_eaddr, f_paddr;
  logic [W-1:0] s_ead = '0, s_ebd = '0, z_ead = '0, z_ebd = '0, f_ead = '0, f_ebd = '0;
  logic signed [W-1:0] s_pxd = '0, s_pyd = '0, z_pxd = '0, z_pyd = '0, f_pxd = '0, f_pyd = '0;

  placement_eval #(.N_GRID(9), .N_EDGE(2), .N_NODE(3), .W(W)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .err(s_err), .err_node(s_en), .cost(s_cost), .max_len(s_ml),
    .edge_re(s_ere), .edge_addr(s_eaddr), .ea_data(s_ead), .eb_data(s_ebd),
    .pos_re(s_pre), .pos_addr(s_paddr), .posx_data(s_pxd), .posy_data(s_pyd));

  placement_eval #(.N_GRID(9), .N_EDGE(0), .N_NODE(3), .W(W)) dut_z (
    .clk(clk), .reset(reset), .start(z_start), .busy(z_busy), .done(z_done),
    .err(z_err), .err_node(z_en), .cost(z_cost), .max_len(z_ml),
    .edge_re(z_ere), .edge_addr(z_eaddr), .ea_data(z_ead), .eb_data(z_ebd),
    .pos_re(z_pre), .pos_addr(z_paddr), .posx_data(z_pxd), .posy_data(z_pyd));

  placement_eval dut_f (
    .clk(clk), .reset(reset), .start(f_start), .busy(f_busy), .done(f_done),
    .err(f_err), .err_node(f_en), .cost(f_cost), .max_len(f_ml),
    .edge_re(f_ere), .edge_addr(f_eaddr), .ea_data(f_ead), .eb_data(f_ebd),
    .pos_re(f_pre), .pos_addr(f_paddr), .posx_data(f_pxd), .posy_data(f_pyd));

  // Synchronous-read memory models, one data port set per DUT.
  always @(posedge clk) begin
    if (s_ere) begin s_ead <= ea_mem[s_eaddr[6:0]]; s_ebd <= eb_mem[s_eaddr[6:0]]; end
    if (s_pre) begin s_pxd <= px_mem[s_paddr[6:0]]; s_pyd <= py_mem[s_paddr[6:0]]; end
    if (z_ere) begin z_ead <= ea_mem[z_eaddr[6:0]]; z_ebd <= eb_mem[z_eaddr[6:0]]; end
    if (z_pre) begin z_pxd <= px_mem[z_paddr[6:0]]; z_pyd <= py_mem[z_paddr[6:0]]; end
    if (f_ere) begin f_ead <= ea_mem[f_eaddr[6:0]]; f_ebd <= eb_mem[f_eaddr[6:0]]; end
    if (f_pre) begin f_pxd <= px_mem[f_paddr[6:0]]; f_pyd <= py_mem[f_paddr[6:0]]; end
  end

  // Edge and position reads must never be in flight together.
  always @(negedge clk) begin
    if (s_ere && s_pre) ovl_s <= ovl_s + 1;
    if (f_ere && f_pre) ovl_f <= ovl_f + 1;
  end

  task automatic chk_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: s_start = v;
      1: z_start = v;
      default: f_start = v;
    endcase
  endtask

  task automatic get_res(input int sel, output logic dn, output logic bs, output logic [1:0] e,
                         output logic [W-1:0] en, output logic [W-1:0] cs, output logic [W-1:0] ml);
    case (sel)
      0: begin dn = s_done; bs = s_busy; e = s_err; en = s_en; cs = s_cost; ml = s_ml; end
      1: begin dn = z_done; bs = z_busy; e = z_err; en = z_en; cs = z_cost; ml = z_ml; end
      default: begin dn = f_done; bs = f_busy; e = f_err; en = f_en; cs = f_cost; ml = f_ml; end
    endcase
  endtask

  // Pulse start, count cycles to done, optionally inject a stray start at cycle inj, then check results.
  task automatic run_chk(input string tag, input int sel, input int inj, input int exp_cyc,
                         input logic [1:0] exp_err, input logic [W-1:0] exp_en,
                         input logic [W-1:0] exp_cost, input logic [W-1:0] exp_ml);
    logic dn, bs;
    logic [1:0] e;
    logic [W-1:0] en, cs, ml;
    int cycles, lows;
    lows = 0;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    cycles = 0;
    get_res(sel, dn, bs, e, en, cs, ml);
    while (!dn && cycles < 2000) begin
      if (!bs) lows++;
      @(negedge clk);
      cycles++;
      set_start(sel, cycles == inj);
      get_res(sel, dn, bs, e, en, cs, ml);
    end
    set_start(sel, 1'b0);
    chk_eq({tag, "_done"}, W'(dn), 1);
    chk_eq({tag, "_latency"}, cycles, exp_cyc);
    chk_eq({tag, "_busy_held"}, lows, 0);
    chk_eq({tag, "_busy_at_done"}, W'(bs), 0);
    chk_eq({tag, "_err"}, W'(e), W'(exp_err));
    chk_eq({tag, "_err_node"}, en, exp_en);
    chk_eq({tag, "_cost"}, cs, exp_cost);
    chk_eq({tag, "_max_len"}, ml, exp_ml);
  endtask

  task automatic set_pos(input int n, input int x, input int y);
    px_mem[n] = x;
    py_mem[n] = y;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    int gc, gm, a, b, d;
    for (int n = 0; n < 128; n++) begin
      ea_mem[n] = '0; eb_mem[n] = '0; px_mem[n] = '0; py_mem[n] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("rst_busy", W'(s_busy), 0);
    chk_eq("rst_done", W'(s_done), 0);
    chk_eq("rst_err", W'(s_err), 0);
    chk_eq("rst_cost", s_cost, 0);
    chk_eq("rst_max_len", s_ml, 0);
    chk_eq("rst_enables", {30'd0, s_ere, s_pre}, 0);

    // 3-node chain: d = 1 then 2 -> cost 0+1, max 2, 7*2+3*3+2 cycles
    ea_mem[0] = 0; eb_mem[0] = 1; ea_mem[1] = 1; eb_mem[1] = 2;
    set_pos(0, 0, 0); set_pos(1, 0, 1); set_pos(2, 2, 1);
    run_chk("chain", 0, 0, 25, 2'd0, 0, 1, 2);

    // node 1 unplaced, found from edge 0 as its sink; restart from DONE clears prior cost
    set_pos(1, -1, -1);
    run_chk("unplaced", 0, 0, 7, 2'd1, 1, 0, 0);

    // no edges: nodes 0 and 2 share (4,4)
    set_pos(0, 4, 4); set_pos(1, 1, 1); set_pos(2, 4, 4);
    run_chk("overlap", 1, 0, 10, 2'd2, 2, 0, 0);

    // x = 9 is one past the last column
    set_pos(0, 9, 0);
    run_chk("x_upper", 1, 0, 4, 2'd1, 0, 0, 0);

    // y = 9 is one past the last row
    set_pos(0, 0, 0); set_pos(1, 0, 9);
    run_chk("y_upper", 1, 0, 7, 2'd1, 1, 0, 0);

    // extreme legal corners
    set_pos(0, 8, 8); set_pos(1, 0, 8); set_pos(2, 8, 0);
    run_chk("corners", 1, 0, 11, 2'd0, 0, 0, 0);

    // reset in PB_WAIT of edge 1, then a clean rerun
    set_pos(0, 0, 0); set_pos(1, 0, 1); set_pos(2, 2, 1);
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (12) @(negedge clk);
    chk_eq("pre_rst_pos_re", W'(s_pre), 1);
    chk_eq("pre_rst_max_len", s_ml, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_eq("mid_rst_busy", W'(s_busy), 0);
    chk_eq("mid_rst_done", W'(s_done), 0);
    chk_eq("mid_rst_max_len", s_ml, 0);
    chk_eq("mid_rst_enables", {30'd0, s_ere, s_pre}, 0);
    run_chk("rerun", 0, 0, 25, 2'd0, 0, 1, 2);

    // full benchmark: 64 distinct legal cells, 91 edges, edge 0 is a self-loop (d = 0)
    for (int n = 0; n < 64; n++) set_pos(n, n / 8, n % 8);
    gc = 0; gm = 0;
    for (int e = 0; e < 91; e++) begin
      a = (e * 7 + 3) % 64;
      b = (e == 0) ? a : (e * 13 + 5) % 64;
      ea_mem[e] = a; eb_mem[e] = b;
      d = iabs(a / 8 - b / 8) + iabs(a % 8 - b % 8);
      gc += d - 1;
      if (d > gm) gm = d;
    end
    run_chk("full", 2, 100, 831, 2'd0, 0, W'(gc), W'(gm));

    chk_eq("enable_overlap_s", ovl_s, 0);
    chk_eq("enable_overlap_f", ovl_f, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
